// File: rtl/ip_bus_pkg.sv
// Shared definitions for the n_cs/n_rd peripheral bus.
// Initiators (ip_bus_reader) and responders (ip_rom and later ones) import
// this package so that the data width, the default address width and the
// initiator state encoding have a single definition.
package ip_bus_pkg;

  localparam int BUS_DATA_W = 8;
  localparam int BUS_ADDR_W = 10;

  // Initiator transaction states:
  //   IDLE - waiting for a start request
  //   REQ  - strobes low for exactly one cycle
  //   WAIT - waiting for the responder's rdata_en
  //   HOLD - byte presented on the output stream, waiting for the sink
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } bus_state_e;

endpackage

// File: rtl/ip_bus_timeout.sv
// Response timeout counter for bus initiators.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - zero the counter (has priority over en)
//   en         - count one waited cycle
//   expired    - the cycle being waited now is the TIMEOUT-th one, so an
//                initiator that still sees no response this cycle gives up
//                at the coming edge
// TIMEOUT must be in 1..2^CNT_W-1.
module ip_bus_timeout #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts waited cycles that are already complete.
  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      // saturates at the limit; the owner leaves its wait state anyway
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ip_bus_reader.sv
// Block-read initiator for the n_cs/n_rd peripheral bus.
// Fetches `length` bytes starting at `start_address`, one outstanding read at
// a time, and delivers them on a valid/ready byte stream.
// Ports:
//   clk, reset_n        - clock, asynchronous active-low reset
//   start               - request pulse, only looked at while idle
//   start_address       - first byte address (captured on start)
//   length              - byte count (captured on start, 0 = empty transfer)
//   abort               - end the current transfer at the next edge
//   busy / done / error - status; done pulses once per transfer, error is
//                         the sticky timeout flag cleared by the next start
//   bus_n_cs, bus_n_rd  - active-low select and read strobe (always together)
//   bus_address         - read address, stable while the strobes are low
//   bus_rdata(_en)      - responder data and its valid
//   o_data, o_valid     - output byte stream
//   i_ready             - sink ready
// All outputs come straight from flops.
module ip_bus_reader
  import ip_bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int LEN_W   = 11,
  parameter int TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_address,
  input  logic [LEN_W-1:0]      length,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  bus_n_cs,
  output logic                  bus_n_rd,
  output logic [ADDR_W-1:0]     bus_address,
  input  logic [BUS_DATA_W-1:0] bus_rdata,
  input  logic                  bus_rdata_en,
  output logic [BUS_DATA_W-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready
);

  bus_state_e            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  strb_n_q, strb_n_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [BUS_DATA_W-1:0] data_q, data_d;
  logic                  valid_q, valid_d;

  logic tmo_clr, tmo_en, tmo_expired;

  ip_bus_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (reset_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            // empty transfer: report completion without touching the bus
            done_d = 1'b1;
          end else begin
            addr_d  = start_address;
            rem_d   = length;
            busy_d  = 1'b1;
            error_d = 1'b0;
            state_d = ST_REQ;
          end
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
        tmo_clr = 1'b1;
      end

      ST_WAIT: begin
        if (bus_rdata_en) begin
          data_d  = bus_rdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          tmo_en = 1'b1;
          if (tmo_expired) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_HOLD: begin
        // rdata_en seen here is a late/duplicate response and is dropped
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          addr_d  = addr_q + 1'b1;   // wraps at the top of the address space
          rem_d   = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_REQ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // abort overrides whatever the state logic decided this cycle, including
    // a data latch or a stream handshake; the error flag is left alone.
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      error_d = error_q;
      valid_d = 1'b0;
      addr_d  = addr_q;
      rem_d   = rem_q;
      data_d  = data_q;
      tmo_en  = 1'b0;
    end

    // strobes are low exactly while the registered state is REQ
    strb_n_d = (state_d != ST_REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      strb_n_q <= 1'b1;
      addr_q   <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      strb_n_q <= strb_n_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign bus_n_cs    = strb_n_q;
  assign bus_n_rd    = strb_n_q;
  assign bus_address = addr_q;
  assign o_data      = data_q;
  assign o_valid     = valid_q;

endmodule

// File: tb/tb_ip_bus_reader.sv
// Bench for ip_bus_reader: a ROM-style responder with optional extra
// latency, stray rdata_en pulses and a mute mode, a random/backpressuring
// sink, and a transfer-level model (expected bytes rom[(a+i) mod 1024],
// read addresses, completion cycle and status) checked per transfer.
module tb_ip_bus_reader;

  localparam int TMO = 8;
  localparam logic [23:0] RST_VEC = {3'b000, 2'b11, 10'd0, 8'd0, 1'b0};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [9:0]  start_address;
  logic [10:0] length;
  logic        abort;
  logic        busy, done, error;
  logic        bus_n_cs, bus_n_rd;
  logic [9:0]  bus_address;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_en;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;

  logic [7:0]  rom [1024];
  int          n_chk  = 0;
  int          n_pass = 0;

  ip_bus_reader #(.ADDR_W(10), .LEN_W(11), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .start_address (start_address),
    .length        (length),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .bus_n_cs      (bus_n_cs),
    .bus_n_rd      (bus_n_rd),
    .bus_address   (bus_address),
    .bus_rdata     (bus_rdata),
    .bus_rdata_en  (bus_rdata_en),
    .o_data        (o_data),
    .o_valid       (o_valid),
    .i_ready       (i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] out_vec();
    return {8'd0, busy, done, error, bus_n_cs, bus_n_rd, bus_address, o_data, o_valid};
  endfunction

  // One transfer. Called just after a negedge; returns just after a negedge.
  // rmode: 0 ready always, 1 random ready, 2 ready low for the first 5
  // o_valid cycles. abort_cyc: observation index at which abort is raised
  // (only if busy). exp_done: expected observation index of done, -1 = any.
  task automatic run_xfer(input int a, input int len, input int rmode, input int dly,
                          input bit mute, input int abort_cyc, input bit noise,
                          input int exp_done, output int n_acc);
    logic [7:0] acc [$];
    logic [9:0] stb [$];
    int         resp_cnt  = 0;
    logic [9:0] resp_addr = '0;
    int         bp_left   = 5;
    int         done_idx  = -1;
    int         abort_idx = -1;
    int         viol      = 0;
    bit         held_v    = 1'b0;
    logic [7:0] held      = '0;
    bit         prev_low  = 1'b0;
    int         budget    = 60 + 40 * len;

    start = 1'b1; start_address = 10'(a); length = 11'(len);
    abort = 1'b0; bus_rdata_en = 1'b0; bus_rdata = '0; i_ready = 1'b1;

    for (int idx = 0; idx < budget; idx++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; bus_rdata_en = 1'b0; bus_rdata = '0;
      if (idx == 0) begin
        chk("busy_on", 32'(busy), 32'(len != 0));
        if (len != 0) begin
          chk("strobe_e0", 32'(bus_n_cs), 32'd0);
          chk("err_clr", 32'(error), 32'd0);
        end
      end
      if (held_v && (!o_valid || o_data != held)) viol++;
      if (bus_n_cs != bus_n_rd) viol++;
      if (!bus_n_cs && (prev_low || o_valid)) viol++;
      prev_low = !bus_n_cs;
      if (done) begin
        done_idx = idx;
        break;
      end
      // responder: answer one cycle (plus dly) after a sampled strobe
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          bus_rdata_en = 1'b1;
          bus_rdata    = rom[resp_addr];
        end
      end else if (noise && !mute && $urandom_range(7) == 0) begin
        bus_rdata_en = 1'b1;
        bus_rdata    = 8'($urandom);
      end
      if (!bus_n_cs) begin
        stb.push_back(bus_address);
        if (!mute) begin
          resp_cnt  = dly + 1;
          resp_addr = bus_address;
        end
      end
      // sink
      case (rmode)
        0:       i_ready = 1'b1;
        1:       i_ready = ($urandom_range(3) != 0);
        default: begin
          i_ready = !(o_valid && bp_left > 0);
          if (o_valid && bp_left > 0) bp_left--;
        end
      endcase
      if (idx == abort_cyc && busy) begin
        abort     = 1'b1;
        abort_idx = idx;
      end
      if (noise && busy && !abort && $urandom_range(9) == 0) begin
        start = 1'b1; start_address = 10'($urandom); length = 11'($urandom_range(1, 5));
      end
      if (o_valid && i_ready && !abort) acc.push_back(o_data);
      held_v = o_valid && !i_ready && !abort;
      held   = o_data;
    end

    n_acc = acc.size();
    chk("done_seen", 32'(done_idx >= 0), 32'd1);
    if (done_idx >= 0) begin
      chk("busy_off", 32'(busy), 32'd0);
      chk("valid_off", 32'(o_valid), 32'd0);
      chk("err_end", 32'(error), 32'(mute));
    end
    if (exp_done >= 0)  chk("done_time", 32'(done_idx), 32'(exp_done));
    if (abort_idx >= 0) chk("abort_time", 32'(done_idx), 32'(abort_idx + 1));
    chk("protocol", 32'(viol), 32'd0);
    if (mute) begin
      chk("nbytes", 32'(n_acc), 32'd0);
      chk("nreads", 32'(stb.size()), 32'd1);
    end else if (abort_idx < 0) begin
      chk("nbytes", 32'(n_acc), 32'(len));
      chk("nreads", 32'(stb.size()), 32'(len));
    end else begin
      chk("nbytes_le", 32'(n_acc <= len), 32'd1);
      chk("nreads_ab", 32'(stb.size() == n_acc || stb.size() == n_acc + 1), 32'd1);
    end
    foreach (stb[i]) chk("addr", 32'(stb[i]), 32'((a + i) % 1024));
    for (int i = 0; i < n_acc && i < len; i++) chk("data", 32'(acc[i]), 32'(rom[(a + i) % 1024]));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; start_address = '0; length = '0; abort = 1'b0;
    bus_rdata = '0; bus_rdata_en = 1'b0; i_ready = 1'b0;
    foreach (rom[i]) rom[i] = 8'($urandom);
    rom[0] = 8'hF3; rom[1] = 8'h31; rom[2] = 8'h00; rom[3] = 8'h00;
    rom[4] = 8'hAF; rom[5] = 8'hD3;

    @(negedge clk);
    chk("reset_state", out_vec(), 32'(RST_VEC));
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset", out_vec(), 32'(RST_VEC));

    run_xfer(0, 4, 0, 0, 1'b0, -1, 1'b0, 12, n);          // 3 cycles/byte
    run_xfer(4, 2, 2, 0, 1'b0, -1, 1'b0, -1, n);          // backpressure
    run_xfer(10'h3FF, 2, 0, 0, 1'b0, -1, 1'b0, 6, n);     // address wrap
    run_xfer(20, 0, 0, 0, 1'b0, -1, 1'b0, 0, n);          // empty transfer
    run_xfer(30, 3, 0, 0, 1'b1, -1, 1'b0, 1 + TMO, n);    // timeout
    @(negedge clk);
    chk("err_hold", 32'(error), 32'd1);
    run_xfer(8, 3, 0, 0, 1'b0, 4, 1'b0, 5, n);            // abort with rdata_en
    chk("abort_bytes", 32'(n), 32'd1);
    run_xfer(100, 6, 1, 1, 1'b0, -1, 1'b1, -1, n);        // stray starts/rdata_en

    // asynchronous reset while holding a byte
    start_address = 10'd4; length = 11'd2; start = 1'b1; i_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk); bus_rdata_en = 1'b1; bus_rdata = rom[4];
    @(negedge clk); bus_rdata_en = 1'b0; bus_rdata = '0;
    chk("hold_valid", 32'(o_valid), 32'd1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1 chk("async_reset", out_vec(), 32'(RST_VEC));
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 25; t++) begin
      int a   = $urandom_range(1023);
      int len = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 8);
      int ab  = ($urandom_range(4) == 0) ? $urandom_range(3 * len + 2) : -1;
      run_xfer(a, len, $urandom_range(1), $urandom_range(3), 1'b0, ab, 1'b1,
               (len == 0) ? 0 : -1, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
